// File: rtl/lsu_pkg.sv
// Shared size/state encodings, default widths and the alignment mask helper
// used by every file of the load/store unit.
package lsu_pkg;

  localparam int LSU_ADDR_W = 12;
  localparam int LSU_DATA_W = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Address LSBs that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(mem_size_e size);
    case (size)
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      SZ_D:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response bus of the LSU.
// master = execute stage, slave = LSU.
interface lsu_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_fault;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_fault, resp_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Misalignment check, load extension and store merge for one access.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic [2:0]        addr_lo,
  input  mem_size_e         size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic              misaligned,
  output logic [DATA_W-1:0] ext_data,
  output logic [DATA_W-1:0] merge_data
);

  logic sign_fill;

  // The DMU returns data starting at the access address, so the operand
  // always sits in the LSBs of rdata regardless of the address offset.
  always_comb begin
    misaligned = |(addr_lo & align_mask(size));
    sign_fill  = 1'b0;
    ext_data   = rdata;
    merge_data = rdata;
    case (size)
      SZ_B: begin
        sign_fill        = ~is_unsigned & rdata[7];
        ext_data         = {{(DATA_W-8){sign_fill}}, rdata[7:0]};
        merge_data[7:0]  = wdata[7:0];
      end
      SZ_H: begin
        sign_fill        = ~is_unsigned & rdata[15];
        ext_data         = {{(DATA_W-16){sign_fill}}, rdata[15:0]};
        merge_data[15:0] = wdata[15:0];
      end
      SZ_W: begin
        sign_fill        = ~is_unsigned & rdata[31];
        ext_data         = {{(DATA_W-32){sign_fill}}, rdata[31:0]};
        merge_data[31:0] = wdata[31:0];
      end
      default: begin
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one aligned memory op at a time against an 8-byte-write DMU.
// Latency handshake->resp: load 2, D store 2, B/H/W store 3 (read-modify-write), fault 1.
// Backpressure: req_ready only in IDLE, so a single op is ever in flight.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_if.slave              bus,
  output logic              dmu_read_en,
  output logic              dmu_write_en,
  output logic [ADDR_W-1:0] dmu_addr,
  output logic [DATA_W-1:0] dmu_wdata,
  input  logic [DATA_W-1:0] dmu_rdata
);

  typedef struct packed {
    logic              store;
    mem_size_e         size;
    logic              is_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  lsu_state_e        state_q, state_d;
  req_t              req_in, req_q;
  logic              fault_q;
  logic [DATA_W-1:0] rdata_q, merge_q;
  logic              accept;

  logic [2:0]        align_addr_lo;
  mem_size_e         align_size;
  logic              align_unsigned;
  logic [DATA_W-1:0] align_wdata;
  logic              misaligned;
  logic [DATA_W-1:0] ext_data, merge_data;

  logic              resp_valid, resp_fault;
  logic [DATA_W-1:0] resp_rdata;

  assign req_in = '{
    store:       bus.req_store,
    size:        mem_size_e'(bus.req_size),
    is_unsigned: bus.req_unsigned,
    addr:        bus.req_addr,
    wdata:       bus.req_wdata
  };

  assign bus.req_ready = (state_q == IDLE) & rst_n;
  assign accept        = bus.req_valid & bus.req_ready;

  // One align instance: live request in IDLE (fault check), held request otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      align_addr_lo  = req_in.addr[2:0];
      align_size     = req_in.size;
      align_unsigned = req_in.is_unsigned;
      align_wdata    = req_in.wdata;
    end else begin
      align_addr_lo  = req_q.addr[2:0];
      align_size     = req_q.size;
      align_unsigned = req_q.is_unsigned;
      align_wdata    = req_q.wdata;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo     (align_addr_lo),
    .size        (align_size),
    .is_unsigned (align_unsigned),
    .rdata       (dmu_rdata),
    .wdata       (align_wdata),
    .misaligned  (misaligned),
    .ext_data    (ext_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_d = RESP;
          end else if (req_in.store && (req_in.size == SZ_D)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD:      state_d = req_q.store ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rdata_q is cleared at accept so stores and faults answer with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        req_q   <= req_in;
        fault_q <= misaligned;
        rdata_q <= '0;
      end
      if (state_q == RD) begin
        if (req_q.store) begin
          merge_q <= merge_data;
        end else begin
          rdata_q <= ext_data;
        end
      end
    end
  end

  always_comb begin
    dmu_read_en  = 1'b0;
    dmu_write_en = 1'b0;
    dmu_addr     = '0;
    dmu_wdata    = '0;
    resp_valid   = 1'b0;
    resp_fault   = 1'b0;
    resp_rdata   = '0;
    case (state_q)
      RD: begin
        dmu_read_en = 1'b1;
        dmu_addr    = req_q.addr;
      end
      WR: begin
        dmu_write_en = 1'b1;
        dmu_addr     = req_q.addr;
        dmu_wdata    = (req_q.size == SZ_D) ? req_q.wdata : merge_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_fault = fault_q;
        resp_rdata = fault_q ? '0 : rdata_q;
      end
      default: ;
    endcase
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_fault = resp_fault;
  assign bus.resp_rdata = resp_rdata;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu with a byte-array DMU and a queue-based reference model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int AW = 12;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          dmu_read_en, dmu_write_en;
  logic [AW-1:0] dmu_addr;
  logic [DW-1:0] dmu_wdata, dmu_rdata;

  lsu #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .dmu_read_en  (dmu_read_en),
    .dmu_write_en (dmu_write_en),
    .dmu_addr     (dmu_addr),
    .dmu_wdata    (dmu_wdata),
    .dmu_rdata    (dmu_rdata)
  );

  // DMU: combinational 8-byte read from addr upward, 8-byte write on the edge.
  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];

  always_comb begin
    dmu_rdata = '0;
    for (int i = 0; i < 8; i++) dmu_rdata[8*i +: 8] = mem[dmu_addr + 12'(i)];
  end

  always @(posedge clk) begin
    if (dmu_write_en)
      for (int i = 0; i < 8; i++) mem[dmu_addr + 12'(i)] <= dmu_wdata[8*i +: 8];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: expected responses with the cycle they are due.
  typedef struct {
    int          due;
    logic        fault;
    logic        store;
    int          nbytes;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;
  exp_t expq[$];

  function automatic logic [63:0] model_load(logic [11:0] a, int n, logic uns);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[12'(a + 12'(i))]) << (8*i));
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  logic [63:0] resp_log[$];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
  end

  initial begin : compare
    exp_t e;
    exp_t n;
    forever begin
      @(negedge clk);
      assert (!(dmu_read_en && dmu_write_en)) else $error("read_en and write_en both high");
      chk("en_exclusive", 64'(dmu_read_en & dmu_write_en), 64'd0);
      if (!dmu_read_en && !dmu_write_en)
        chk("dmu_bus_idle_zero", 64'((dmu_addr == '0) && (dmu_wdata == '0)), 64'd1);
      if (!rst_n) begin
        expq.delete();
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      end else begin
        chk("ready_iff_idle", 64'(bus.req_ready), 64'(expq.size() == 0));
        if (expq.size() > 0 && expq[0].due == cyc) begin
          e = expq.pop_front();
          chk("resp_valid", 64'(bus.resp_valid), 64'd1);
          chk("resp_fault", 64'(bus.resp_fault), 64'(e.fault));
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          if (e.store && !e.fault)
            for (int i = 0; i < e.nbytes; i++) ref_mem[12'(e.addr + 12'(i))] = e.wdata[8*i +: 8];
        end else begin
          chk("resp_valid_quiet", 64'(bus.resp_valid), 64'd0);
        end
        if (bus.resp_valid) resp_log.push_back(bus.resp_rdata);
        if (bus.req_valid && bus.req_ready) begin
          n.store  = bus.req_store;
          n.nbytes = 1 << bus.req_size;
          n.addr   = bus.req_addr;
          n.wdata  = bus.req_wdata;
          n.fault  = (int'(bus.req_addr) % n.nbytes) != 0;
          n.rdata  = (n.fault || n.store) ? 64'd0 : model_load(n.addr, n.nbytes, bus.req_unsigned);
          n.due    = cyc + (n.fault ? 1 : ((n.store && n.nbytes < 8) ? 3 : 2));
          expq.push_back(n);
        end
      end
    end
  end

  task automatic drive(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [63:0] wd);
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  // Called just after a rising edge; returns just after the edge following RESP.
  task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic flt, output int lat,
                       output logic en_seen);
    int w;
    drive(st, sz, uns, a, wd);
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    en_seen = dmu_read_en | dmu_write_en;
    while (!bus.resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      en_seen = en_seen | dmu_read_en | dmu_write_en;
    end
    chk("resp_timeout", 64'(bus.resp_valid), 64'd1);
    rd  = bus.resp_rdata;
    flt = bus.resp_fault;
    @(posedge clk); #1;
  endtask

  task automatic mem_compare(input string name);
    int diff;
    diff = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diff++;
    chk(name, 64'(diff), 64'd0);
  endtask

  logic [63:0] rd;
  logic        flt, en;
  int          lat;

  initial begin : stim
    int k, w, base;
    logic [11:0] burst_addr [4];
    logic [1:0]  burst_size [4];
    logic        burst_uns  [4];
    bus.req_valid = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 12'h0, 64'h0);

    #2;
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_dmu_en", 64'({dmu_read_en, dmu_write_en}), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: doubleword store then load
    do_op(1'b1, 2'd3, 1'b0, 12'h010, 64'h1122334455667788, rd, flt, lat, en);
    chk("t1_sd_latency", 64'(lat), 64'd2);
    do_op(1'b0, 2'd3, 1'b0, 12'h010, 64'h0, rd, flt, lat, en);
    chk("t1_ld_latency", 64'(lat), 64'd2);
    chk("t1_ld_data", rd, 64'h1122334455667788);

    // 2: byte store is read-modify-write
    do_op(1'b1, 2'd0, 1'b0, 12'h013, 64'h00000000000000AB, rd, flt, lat, en);
    chk("t2_sb_latency", 64'(lat), 64'd3);
    do_op(1'b0, 2'd3, 1'b0, 12'h010, 64'h0, rd, flt, lat, en);
    chk("t2_ld_data", rd, 64'h11223344AB667788);

    // 3: halfword store, signed/unsigned/word loads
    do_op(1'b1, 2'd1, 1'b0, 12'h020, 64'h0000000000008001, rd, flt, lat, en);
    chk("t3_sh_latency", 64'(lat), 64'd3);
    do_op(1'b0, 2'd1, 1'b0, 12'h020, 64'h0, rd, flt, lat, en);
    chk("t3_lh", rd, 64'hFFFFFFFFFFFF8001);
    do_op(1'b0, 2'd1, 1'b1, 12'h020, 64'h0, rd, flt, lat, en);
    chk("t3_lhu", rd, 64'h0000000000008001);
    do_op(1'b0, 2'd2, 1'b0, 12'h020, 64'h0, rd, flt, lat, en);
    chk("t3_lw", rd, 64'h0000000000008001);

    // 4: misaligned accesses fault without touching the DMU
    do_op(1'b0, 2'd2, 1'b0, 12'h006, 64'h0, rd, flt, lat, en);
    chk("t4_lw_fault", 64'(flt), 64'd1);
    chk("t4_lw_latency", 64'(lat), 64'd1);
    chk("t4_lw_rdata", rd, 64'd0);
    chk("t4_lw_no_dmu", 64'(en), 64'd0);
    do_op(1'b1, 2'd3, 1'b0, 12'h00C, 64'hDEADBEEFDEADBEEF, rd, flt, lat, en);
    chk("t4_sd_fault", 64'(flt), 64'd1);
    chk("t4_sd_latency", 64'(lat), 64'd1);
    chk("t4_sd_no_dmu", 64'(en), 64'd0);
    mem_compare("t4_mem_unchanged");

    // 5: reset during WR cancels the write and the response
    drive(1'b1, 2'd3, 1'b0, 12'h040, 64'hFFFFFFFFFFFFFFFF);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("t5_in_wr", 64'(dmu_write_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_write_dropped", 64'(dmu_write_en), 64'd0);
    chk("t5_ready_in_reset", 64'(bus.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("t5_ready_after_reset", 64'(bus.req_ready), 64'd1);
    do_op(1'b0, 2'd3, 1'b0, 12'h040, 64'h0, rd, flt, lat, en);
    chk("t5_ld_zero", rd, 64'd0);
    mem_compare("t5_mem_no_write");

    // 6: back-to-back loads with req_valid held high
    do_op(1'b1, 2'd3, 1'b0, 12'h080, 64'h0123456789ABCDEF, rd, flt, lat, en);
    do_op(1'b1, 2'd3, 1'b0, 12'h088, 64'hFEDCBA9876543210, rd, flt, lat, en);
    burst_addr = '{12'h080, 12'h088, 12'h08C, 12'h08F};
    burst_size = '{2'd3, 2'd2, 2'd2, 2'd0};
    burst_uns  = '{1'b0, 1'b0, 1'b0, 1'b0};
    base = resp_log.size();
    k = 0;
    w = 0;
    drive(1'b0, burst_size[0], burst_uns[0], burst_addr[0], 64'h0);
    bus.req_valid = 1'b1;
    while (k < 4 && w < 60) begin
      @(negedge clk);
      w++;
      if (bus.req_ready) begin
        @(posedge clk); #1;
        k++;
        if (k < 4) drive(1'b0, burst_size[k], burst_uns[k], burst_addr[k], 64'h0);
        else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    chk("t6_accepts", 64'(k), 64'd4);
    repeat (6) @(posedge clk);
    #1;
    chk("t6_resp_count", 64'(resp_log.size() - base), 64'd4);
    if (resp_log.size() - base == 4) begin
      chk("t6_resp0", resp_log[base],   64'h0123456789ABCDEF);
      chk("t6_resp1", resp_log[base+1], 64'h0000000076543210);
      chk("t6_resp2", resp_log[base+2], 64'hFFFFFFFFFEDCBA98);
      chk("t6_resp3", resp_log[base+3], 64'hFFFFFFFFFFFFFFFE);
    end
    mem_compare("final_mem_image");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
